// File: rtl/jk_seq_pkg.sv
// jk_seq_pkg: op codes, FSM states and JK cell drive codes shared by the sequencer
package jk_seq_pkg;
  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_TOGGLE = 3'd4;
  localparam logic [2:0] OP_CNT_UP = 3'd5;
  localparam logic [2:0] OP_CNT_DN = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;
  typedef enum logic {ST_IDLE, ST_EXEC} state_t;
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;
  function automatic logic [1:0] jk_code(input logic [2:0] op, input logic a, input logic up, input logic dn);
    return op == OP_CLEAR  ? JK_RST :
           op == OP_SET    ? JK_SET :
           op == OP_LOAD   ? (a ? JK_SET : JK_RST) :
           op == OP_TOGGLE ? (a ? JK_TGL : JK_HOLD) :
           op == OP_CNT_UP ? (up ? JK_TGL : JK_HOLD) :
           op == OP_CNT_DN ? (dn ? JK_TGL : JK_HOLD) : JK_HOLD;
  endfunction
endpackage

// File: rtl/jk_reg_sequencer_if.sv
// jk_reg_sequencer_if: command handshake and bank status bundle
interface jk_reg_sequencer_if #(parameter int WIDTH = 4, parameter int CNT_W = 8);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_arg;
  logic [CNT_W-1:0] cmd_len;
  logic             abort;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             err;
  modport master (output cmd_valid, cmd_op, cmd_arg, cmd_len, abort, input cmd_ready, q, busy, done, err);
  modport slave  (input cmd_valid, cmd_op, cmd_arg, cmd_len, abort, output cmd_ready, q, busy, done, err);
endinterface

// File: rtl/jk_reg_sequencer_bit.sv
// jk_bit: single JK flip-flop cell with async active-high reset
module jk_bit (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= 1'b0;
    else     q <= j ? (k ? ~q : 1'b1) : (k ? 1'b0 : q);
  assign qbar = ~q;
endmodule

// File: rtl/jk_reg_sequencer.sv
// jk_reg_sequencer: command FSM sequencing the J/K drive of a bank of JK cells
module jk_reg_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  jk_reg_sequencer_if.slave bus
);
  state_t           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] arg_q;
  logic [CNT_W-1:0] rem_q;
  logic             done_q, err_q;
  logic [WIDTH-1:0] q_s, qb_s, j_s, k_s, up_t, dn_t;
  logic             is_cnt, bad, abort_hit, step, last;
  assign is_cnt    = op_q == OP_CNT_UP || op_q == OP_CNT_DN;
  assign bad       = op_q == OP_RSVD || (is_cnt && rem_q == '0);
  assign abort_hit = is_cnt && bus.abort;
  assign step      = state_q == ST_EXEC && !bad && !abort_hit;
  assign last      = !is_cnt || bad || abort_hit || rem_q == CNT_W'(1);
  always_comb begin
    up_t = '0;
    dn_t = '0;
    j_s  = '0;
    k_s  = '0;
    up_t[0] = 1'b1;
    dn_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_t[i] = up_t[i-1] & q_s[i-1];
      dn_t[i] = dn_t[i-1] & qb_s[i-1];
    end
    for (int i = 0; i < WIDTH; i++)
      {j_s[i], k_s[i]} = step ? jk_code(op_q, arg_q[i], up_t[i], dn_t[i]) : JK_HOLD;
  end
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_bit u_bit (.clk(clk), .rst(rst), .j(j_s[g]), .k(k_s[g]), .q(q_s[g]), .qbar(qb_s[g]));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_NOP;
      arg_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (bus.cmd_valid) begin
          state_q <= ST_EXEC;
          op_q    <= bus.cmd_op;
          arg_q   <= bus.cmd_arg;
          rem_q   <= bus.cmd_len;
        end
      end else begin
        rem_q <= rem_q - 1'b1;
        if (last) begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
          err_q   <= bad || abort_hit;
        end
      end
    end
  assign bus.cmd_ready = state_q == ST_IDLE && !rst;
  assign bus.busy      = state_q == ST_EXEC;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.q         = q_s;
endmodule

// File: tb/tb_jk_reg_sequencer.sv
// tb_jk_reg_sequencer: table-driven command vectors plus hand sequences for stepping, abort and reset
module tb_jk_reg_sequencer;
  import jk_seq_pkg::*;
  typedef struct {
    logic [2:0] op;
    logic [3:0] arg;
    logic [7:0] len;
    logic [3:0] q;
    logic       err;
    int         cyc;
  } vec_t;
  logic clk, rst;
  int checks = 0, failures = 0;
  vec_t vecs[14];
  logic [3:0] up_seq[5];
  jk_reg_sequencer_if #(.WIDTH(4), .CNT_W(8)) bus ();
  jk_reg_sequencer #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [3:0] arg, input logic [7:0] len);
    int n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    bus.cmd_len   = len;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] arg, input logic [7:0] len, output int cyc);
    issue(op, arg, len);
    cyc = 0;
    while (bus.busy && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
  endtask
  initial begin
    int cyc;
    vecs[0]  = '{OP_LOAD,   4'hA, 8'd0, 4'hA, 1'b0, 1};
    vecs[1]  = '{OP_CLEAR,  4'h0, 8'd0, 4'h0, 1'b0, 1};
    vecs[2]  = '{OP_SET,    4'h0, 8'd0, 4'hF, 1'b0, 1};
    vecs[3]  = '{OP_TOGGLE, 4'h5, 8'd0, 4'hA, 1'b0, 1};
    vecs[4]  = '{OP_NOP,    4'hF, 8'd9, 4'hA, 1'b0, 1};
    vecs[5]  = '{OP_LOAD,   4'hD, 8'd7, 4'hD, 1'b0, 1};
    vecs[6]  = '{OP_CNT_UP, 4'h0, 8'd5, 4'h2, 1'b0, 5};
    vecs[7]  = '{OP_LOAD,   4'h1, 8'd0, 4'h1, 1'b0, 1};
    vecs[8]  = '{OP_CNT_DN, 4'h0, 8'd3, 4'hE, 1'b0, 3};
    vecs[9]  = '{OP_TOGGLE, 4'h5, 8'd0, 4'hB, 1'b0, 1};
    vecs[10] = '{OP_CNT_UP, 4'h0, 8'd0, 4'hB, 1'b1, 1};
    vecs[11] = '{OP_RSVD,   4'h3, 8'd4, 4'hB, 1'b1, 1};
    vecs[12] = '{OP_CNT_DN, 4'h0, 8'd1, 4'hA, 1'b0, 1};
    vecs[13] = '{OP_CNT_UP, 4'h0, 8'd20, 4'hE, 1'b0, 20};
    up_seq = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h2};
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_NOP;
    bus.cmd_arg   = '0;
    bus.cmd_len   = '0;
    bus.abort     = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_q", 32'(bus.q), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_ready", 32'(bus.cmd_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(bus.cmd_ready), 1);
    // first LOAD by hand: ready low while executing, done exactly one cycle
    issue(OP_LOAD, 4'hA, 8'd0);
    chk("load_busy", 32'(bus.busy), 1);
    chk("load_ready_exec", 32'(bus.cmd_ready), 0);
    @(negedge clk);
    chk("load_q", 32'(bus.q), 4'hA);
    chk("load_done", 32'(bus.done), 1);
    chk("load_err", 32'(bus.err), 0);
    @(negedge clk);
    chk("load_done_1cyc", 32'(bus.done), 0);
    for (int i = 0; i < 14; i++) begin
      do_cmd(vecs[i].op, vecs[i].arg, vecs[i].len, cyc);
      chk($sformatf("vec%0d_cyc", i), 32'(cyc), 32'(vecs[i].cyc));
      chk($sformatf("vec%0d_q", i), 32'(bus.q), 32'(vecs[i].q));
      chk($sformatf("vec%0d_done", i), 32'(bus.done), 1);
      chk($sformatf("vec%0d_err", i), 32'(bus.err), 32'(vecs[i].err));
    end
    // per-step count up from D wrapping through 0
    do_cmd(OP_LOAD, 4'hD, 8'd0, cyc);
    issue(OP_CNT_UP, 4'h0, 8'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("cu_busy%0d", i), 32'(bus.busy), 1);
      chk($sformatf("cu_ready%0d", i), 32'(bus.cmd_ready), 0);
      @(negedge clk);
      chk($sformatf("cu_q%0d", i), 32'(bus.q), 32'(up_seq[i]));
    end
    chk("cu_done", 32'(bus.done), 1);
    chk("cu_busy_end", 32'(bus.busy), 0);
    // abort is ignored during single-step ops
    bus.abort = 1'b1;
    do_cmd(OP_LOAD, 4'h0, 8'd0, cyc);
    chk("abort_ss_q", 32'(bus.q), 0);
    chk("abort_ss_err", 32'(bus.err), 0);
    bus.abort = 1'b0;
    issue(OP_CNT_UP, 4'h0, 8'd10);
    repeat (3) @(negedge clk);
    chk("abort_pre_q", 32'(bus.q), 3);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_q", 32'(bus.q), 3);
    chk("abort_done", 32'(bus.done), 1);
    chk("abort_err", 32'(bus.err), 1);
    chk("abort_ready", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_SET;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("abort_next_busy", 32'(bus.busy), 1);
    chk("abort_q_hold", 32'(bus.q), 3);
    @(negedge clk);
    chk("abort_next_q", 32'(bus.q), 4'hF);
    chk("abort_next_err", 32'(bus.err), 0);
    // abort on the final step suppresses it
    do_cmd(OP_LOAD, 4'h0, 8'd0, cyc);
    issue(OP_CNT_UP, 4'h0, 8'd2);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_last_q", 32'(bus.q), 1);
    chk("abort_last_err", 32'(bus.err), 1);
    // reset mid count
    do_cmd(OP_LOAD, 4'h0, 8'd0, cyc);
    issue(OP_CNT_UP, 4'h0, 8'd10);
    repeat (2) @(negedge clk);
    chk("mid_pre_q", 32'(bus.q), 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_q", 32'(bus.q), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_ready", 32'(bus.cmd_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rel_ready", 32'(bus.cmd_ready), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mid_nodone%0d", i), 32'(bus.done), 0);
    end
    do_cmd(OP_SET, 4'h0, 8'd0, cyc);
    chk("mid_set_q", 32'(bus.q), 4'hF);
    chk("mid_set_done", 32'(bus.done), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
